// File: rtl/stack_unit_if.sv
// Stack unit bus: push/pop request side plus status and read-back.
// Optional STACK_PEEK_EN adds the tos/tos_valid peek outputs.
interface stack_unit_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] wdata;
  logic              clr_err;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic [CW-1:0]     count;
  logic [31:0]       sp;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              udf;
`ifdef STACK_PEEK_EN
  logic [DATA_W-1:0] tos;
  logic              tos_valid;
`endif

  modport master (
    output push, pop, wdata, clr_err,
    input  rdata, rvalid, count, sp, full, empty, ovf, udf
`ifdef STACK_PEEK_EN
    , input tos, tos_valid
`endif
  );

  modport slave (
    input  push, pop, wdata, clr_err,
    output rdata, rvalid, count, sp, full, empty, ovf, udf
`ifdef STACK_PEEK_EN
    , output tos, tos_valid
`endif
  );
endinterface

// File: rtl/stack_unit.sv
// LIFO stack with byte stack pointer, registered pop data and sticky
// overflow/underflow flags. Push+pop in one cycle replaces the TOS.
// Optional feature: define STACK_PEEK_EN for tos/tos_valid outputs.
module stack_unit #(
  parameter int          DATA_W  = 16,
  parameter int          DEPTH   = 16,
  parameter logic [31:0] SP_BASE = 32'h0000_0FFE
) (
  input  logic        clk,
  input  logic        rst,
  stack_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] BPW = 32'(DATA_W / 8);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_ovf;
  logic              r_udf;

  logic              w_full, w_empty;
  logic              w_do_pop, w_do_push, w_replace;
  logic [CW-1:0]     w_cnt_m1;
  logic [AW-1:0]     w_tos_idx, w_wr_idx;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_cnt_m1  = r_count - CW'(1);
  assign w_tos_idx = w_cnt_m1[AW-1:0];
  assign w_wr_idx  = r_count[AW-1:0];

  // Pop wins over an empty stack only by being rejected; a push paired with
  // a valid pop becomes a TOS replace, otherwise it needs free space.
  assign w_do_pop  = bus.pop && !w_empty;
  assign w_replace = bus.push && w_do_pop;
  assign w_do_push = bus.push && !w_do_pop && !w_full;

  // Storage array: no reset, contents meaningless until written
  always_ff @(posedge clk) begin
    if (w_do_push)      r_mem[w_wr_idx]  <= bus.wdata;
    else if (w_replace) r_mem[w_tos_idx] <= bus.wdata;
  end

  // Occupancy, pop data, strobe and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_rvalid <= w_do_pop;
      if (w_do_pop) r_rdata <= r_mem[w_tos_idx];

      if (w_do_push)                 r_count <= r_count + CW'(1);
      else if (w_do_pop && !bus.push) r_count <= w_cnt_m1;

      // set has priority over clear
      if (bus.push && !bus.pop && w_full) r_ovf <= 1'b1;
      else if (bus.clr_err)               r_ovf <= 1'b0;

      if (bus.pop && w_empty) r_udf <= 1'b1;
      else if (bus.clr_err)   r_udf <= 1'b0;
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.count  = r_count;
  assign bus.sp     = SP_BASE - 32'(r_count) * BPW;
  assign bus.full   = w_full;
  assign bus.empty  = w_empty;
  assign bus.ovf    = r_ovf;
  assign bus.udf    = r_udf;

`ifdef STACK_PEEK_EN
  // Last-write capture so tos does not depend on array write timing if the
  // array is later mapped onto a memory macro with delayed write-through.
  logic              r_byp_vld;
  logic [AW-1:0]     r_byp_idx;
  logic [DATA_W-1:0] r_byp_data;

  // Record the index/data of the most recent array write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byp_vld  <= 1'b0;
      r_byp_idx  <= '0;
      r_byp_data <= '0;
    end else begin
      r_byp_vld <= w_do_push || w_replace;
      if (w_do_push || w_replace) begin
        r_byp_idx  <= w_do_push ? w_wr_idx : w_tos_idx;
        r_byp_data <= bus.wdata;
      end
    end
  end

  assign bus.tos       = (r_byp_vld && r_byp_idx == w_tos_idx) ? r_byp_data
                                                               : r_mem[w_tos_idx];
  assign bus.tos_valid = !w_empty;
`endif
endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit (DEPTH=4, DATA_W=16) with immediate
// assertions against hand-computed values.
module tb_stack_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec  = 0;
  int   n_fail = 0;

  stack_unit_if #(.DATA_W(16), .DEPTH(4)) bus ();

  stack_unit #(.DATA_W(16), .DEPTH(4), .SP_BASE(32'h0000_0FFE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of requests, sample 1ns after the edge, then go idle.
  task automatic cyc(input logic p, input logic q, input logic [15:0] d, input logic c);
    bus.push = p; bus.pop = q; bus.wdata = d; bus.clr_err = c;
    @(posedge clk); #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0;
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.wdata = '0; bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_sp",    bus.sp,         32'h0000_0FFE);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full",  32'(bus.full),  32'd0);
    chk("rst_rvld",  32'(bus.rvalid),32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_flags", {30'd0, bus.ovf, bus.udf}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // three pushes
    cyc(1, 0, 16'h1111, 0);
    cyc(1, 0, 16'h2222, 0);
    cyc(1, 0, 16'h3333, 0);
    chk("p3_count", 32'(bus.count), 32'd3);
    chk("p3_sp",    bus.sp,         32'h0000_0FF8);
    chk("p3_ef",    {30'd0, bus.empty, bus.full}, 32'd0);

    // fill, then overflow
    cyc(1, 0, 16'h4444, 0);
    chk("p4_full",  32'(bus.full),  32'd1);
    chk("p4_sp",    bus.sp,         32'h0000_0FF6);
    cyc(1, 0, 16'h5555, 0);
    chk("ovf_set",  32'(bus.ovf),   32'd1);
    chk("ovf_cnt",  32'(bus.count), 32'd4);

    // drain in LIFO order
    cyc(0, 1, 16'h0, 0);
    chk("pop1_vld", 32'(bus.rvalid), 32'd1);
    chk("pop1_dat", 32'(bus.rdata),  32'h4444);
    chk("pop1_cnt", 32'(bus.count),  32'd3);
    cyc(0, 1, 16'h0, 0);
    chk("pop2_dat", 32'(bus.rdata),  32'h3333);
    cyc(0, 1, 16'h0, 0);
    chk("pop3_dat", 32'(bus.rdata),  32'h2222);
    cyc(0, 1, 16'h0, 0);
    chk("pop4_dat", 32'(bus.rdata),  32'h1111);
    chk("pop4_emp", 32'(bus.empty),  32'd1);
    cyc(0, 0, 16'h0, 0);
    chk("idle_vld", 32'(bus.rvalid), 32'd0);
    chk("idle_hold",32'(bus.rdata),  32'h1111);
    chk("ovf_stky", 32'(bus.ovf),    32'd1);
    cyc(0, 0, 16'h0, 1);
    chk("ovf_clr",  32'(bus.ovf),    32'd0);

    // push+pop replaces TOS
    cyc(1, 0, 16'hAAAA, 0);
    cyc(1, 1, 16'hBBBB, 0);
    chk("rep_vld",  32'(bus.rvalid), 32'd1);
    chk("rep_dat",  32'(bus.rdata),  32'hAAAA);
    chk("rep_cnt",  32'(bus.count),  32'd1);
    cyc(0, 1, 16'h0, 0);
    chk("rep_pop",  32'(bus.rdata),  32'hBBBB);
    chk("rep_emp",  32'(bus.count),  32'd0);

    // underflow, clear, and set-wins
    cyc(0, 1, 16'h0, 0);
    chk("udf_set",  32'(bus.udf),    32'd1);
    chk("udf_vld",  32'(bus.rvalid), 32'd0);
    chk("udf_cnt",  32'(bus.count),  32'd0);
    cyc(0, 0, 16'h0, 1);
    chk("udf_clr",  32'(bus.udf),    32'd0);
    cyc(0, 1, 16'h0, 1);
    chk("udf_win",  32'(bus.udf),    32'd1);
    cyc(0, 0, 16'h0, 1);

    // push+pop on empty: pop rejected, push executes
    cyc(1, 1, 16'h7777, 0);
    chk("pe_udf",   32'(bus.udf),    32'd1);
    chk("pe_vld",   32'(bus.rvalid), 32'd0);
    chk("pe_cnt",   32'(bus.count),  32'd1);
    cyc(0, 1, 16'h0, 0);
    chk("pe_pop",   32'(bus.rdata),  32'h7777);

    // push+pop while full is a legal replace, no overflow
    cyc(1, 0, 16'h0001, 0);
    cyc(1, 0, 16'h0002, 0);
    cyc(1, 0, 16'h0003, 0);
    cyc(1, 0, 16'h0004, 0);
    cyc(1, 1, 16'h9999, 0);
    chk("fr_dat",   32'(bus.rdata),  32'h0004);
    chk("fr_cnt",   32'(bus.count),  32'd4);
    chk("fr_ovf",   32'(bus.ovf),    32'd0);
    cyc(0, 1, 16'h0, 0);
    chk("fr_pop",   32'(bus.rdata),  32'h9999);
    cyc(0, 1, 16'h0, 0);
    cyc(0, 1, 16'h0, 0);
    cyc(0, 1, 16'h0, 0);
    chk("fr_emp",   32'(bus.empty),  32'd1);

    // reset mid-operation discards the in-flight pop
    cyc(1, 0, 16'h00A1, 0);
    cyc(1, 0, 16'h00A2, 0);
    cyc(0, 1, 16'h0, 0);
    rst = 1'b0;
    #1;
    chk("mr_vld",   32'(bus.rvalid), 32'd0);
    chk("mr_cnt",   32'(bus.count),  32'd0);
    chk("mr_sp",    bus.sp,          32'h0000_0FFE);
    chk("mr_flags", {30'd0, bus.ovf, bus.udf}, 32'd0);
    chk("mr_rdata", 32'(bus.rdata),  32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc(0, 0, 16'h0, 0);
    chk("mr_post",  32'(bus.rvalid), 32'd0);

`ifdef STACK_PEEK_EN
    cyc(1, 0, 16'hCAFE, 0);
    chk("pk_tos",   32'(bus.tos),       32'h0000_CAFE);
    chk("pk_tv",    32'(bus.tos_valid), 32'd1);
    cyc(0, 1, 16'h0, 0);
    chk("pk_tv0",   32'(bus.tos_valid), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
